// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard receiver: synchronizes the pad, deframes 11-bit frames, tracks
// E0/F0 prefixes and shift state, and queues decoded key events in a small FIFO.
module ps2_key_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic                          evt_shift,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned EW = 11;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Pad synchronizers; reset high so a reset never looks like a falling edge.
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s2_q, dat_s2_d;
  logic fall;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat;
    dat_s2_d   = dat_s1_q;
    fall       = clk_prev_q & ~clk_s2_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_e      state_q;
  logic [2:0]     bit_cnt_q;
  logic [TW-1:0]  tmo_q;
  logic [7:0]     shreg_q;
  logic           par_q;
  logic [7:0]     byte_q;
  logic           byte_valid_q;
  logic           frame_err_q;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_q     <= '0;
        bit_cnt_q <= '0;
        if (fall && !dat_s2_q) begin
          state_q <= S_DATA;
        end
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          S_DATA: begin
            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            // Accept only a high stop bit with odd parity over data+parity.
            if (dat_s2_q && (^{shreg_q, par_q})) begin
              byte_q       <= shreg_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        frame_err_q <= 1'b1;
        tmo_q       <= '0;
        state_q     <= S_IDLE;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix / shift decoder
  // ---------------------------------------------------------------------------
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          shift_q, shift_d;
  logic          push;
  logic [EW-1:0] push_evt;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_evt   = '0;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        if (!ext_pend_q && (byte_q == 8'h12 || byte_q == 8'h59)) begin
          shift_d = ~brk_pend_q;
        end
        push       = 1'b1;
        push_evt   = {shift_d, ext_pend_q, brk_pend_q, byte_q};
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      shift_q    <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [EW-1:0] head;

  always_comb begin
    pop     = evt_valid & evt_ready;
    full    = (count_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push & (~full | pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q | (push & ~push_ok);
    if (push_ok) begin
      mem_d[wr_q] = push_evt;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  always_comb begin
    evt_valid  = (count_q != '0);
    head       = evt_valid ? mem_q[rd_q] : '0;
    evt_code   = head[7:0];
    evt_break  = head[8];
    evt_ext    = head[9];
    evt_shift  = head[10];
    fifo_count = count_q;
    frame_err  = frame_err_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: bit-banged PS/2 frames, directed cases plus a
// randomized stream, checked against a queue-based key-event model.
module tb_ps2_key_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HALF  = 20;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       evt_shift;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       frame_err;
  logic       overflow;

  logic ready_fix;
  logic ready_rnd;
  logic rand_mode;
  assign evt_ready = rand_mode ? ready_rnd : ready_fix;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_key_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .evt_shift (evt_shift),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_fall = 0;
  int err_seen  = 0;
  int exp_err   = 0;

  // Model: expected events are {shift, ext, break, code}.
  logic [10:0] exp_q[$];
  bit m_ext, m_brk, m_shift, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [10:0] ev;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      ev = {m_shift, m_ext, m_brk, b};
      if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
      else exp_q.push_back(ev);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(posedge CLOCK_50) begin
    #1;
    ready_rnd = 1'($urandom_range(0, 1));
  end

  // Consumer-side monitor: checks every popped event and head stability.
  logic [10:0] mon_head, mon_exp, hold_v;
  bit hold_q = 1'b0;
  always @(negedge CLOCK_50) begin
    mon_head = {evt_shift, evt_ext, evt_break, evt_code};
    if (Resetn) begin
      if (frame_err) err_seen++;
      if (hold_q) check_eq("head_hold", 32'(mon_head), 32'(hold_v));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check_eq("evt_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          mon_exp = exp_q.pop_front();
          check_eq("evt", 32'(mon_head), 32'(mon_exp));
        end
      end
    end
    hold_q = Resetn && evt_valid && !evt_ready;
    hold_v = mon_head;
  end

  task automatic settle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    if (chk) begin
      check_eq("rst_valid", 32'(evt_valid), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_code", 32'(evt_code), 32'd0);
      check_eq("rst_flags", 32'({evt_break, evt_ext, evt_shift}), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
    end
    @(posedge CLOCK_50);
    #1;
    Resetn = 1'b1;
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0; m_ovf = 1'b0;
  endtask

  // Sends the first nbits of an 11-bit frame; chk_lat checks evt_valid timing
  // relative to the stop-bit falling edge (2 sync stages + edge + 2 cycles).
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit chk_lat);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      settle(HALF);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        if (bad) exp_err++;
        else model_byte(b);
        if (chk_lat) begin
          repeat (4) @(negedge CLOCK_50);
          check_eq("lat_pre", 32'(evt_valid), 32'd0);
          @(negedge CLOCK_50);
          check_eq("lat_rise", 32'(evt_valid), 32'd1);
        end
      end
      settle(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    settle(HALF);
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_frame(bytes[i], 1'b0, 11, 1'b0);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got no completion, required finish within 90000 cycles");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int delta;
    int err_before;
    Resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    ready_fix = 1'b1; rand_mode = 1'b0;
    do_reset(1'b1);
    settle(5);

    // Single make code with latency check
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    settle(10);
    check_eq("drain_1c", 32'(exp_q.size()), 32'd0);

    // Shift make/break sequence
    send_list('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
    settle(10);
    check_eq("drain_shift", 32'(exp_q.size()), 32'd0);

    // Extended codes; extended shift never changes shift state
    send_list('{8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'hF0, 8'h12});
    settle(10);
    check_eq("drain_ext", 32'(exp_q.size()), 32'd0);

    // Bad parity frames are rejected and leave prefixes intact
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    settle(10);
    check_eq("perr_count", 32'(err_seen), 32'(exp_err));
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    settle(10);
    check_eq("perr_count2", 32'(err_seen), 32'(exp_err));
    check_eq("drain_perr", 32'(exp_q.size()), 32'd0);

    // Overflow with stalled consumer
    ready_fix = 1'b0;
    send_list('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
    settle(10);
    check_eq("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'(m_ovf));
    ready_fix = 1'b1;
    settle(10);
    check_eq("drain_ovf", 32'(exp_q.size()), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Truncated frame: timeout error, then normal decode
    send_frame(8'($urandom_range(0, 255)), 1'b0, 6, 1'b0);
    while (!frame_err && (cyc - last_fall) < int'(TMO + 20)) @(negedge CLOCK_50);
    delta = cyc - last_fall;
    exp_err++;
    check_eq("tmo_seen", 32'(frame_err), 32'd1);
    check_eq("tmo_window", 32'(delta >= int'(TMO + 1) && delta <= int'(TMO + 6)), 32'd1);
    settle(5);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    settle(10);
    check_eq("tmo_errs", 32'(err_seen), 32'(exp_err));
    check_eq("drain_tmo", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame: partial frame vanishes silently
    send_frame(8'h12, 1'b0, 4, 1'b0);
    err_before = err_seen;
    do_reset(1'b1);
    settle(TMO + 20);
    check_eq("midrst_err", 32'(err_seen), 32'(err_before));
    check_eq("midrst_count", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    settle(10);
    check_eq("drain_midrst", 32'(exp_q.size()), 32'd0);

    // Randomized stream with a randomly stalling consumer
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h12;
        1: b = 8'h59;
        2: b = 8'hE0;
        3: b = 8'hF0;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
        end
      endcase
      send_frame(b, ($urandom_range(0, 9) == 0), 11, 1'b0);
      settle(int'($urandom_range(0, 30)));
    end
    rand_mode = 1'b0;
    ready_fix = 1'b1;
    settle(20);
    check_eq("drain_rand", 32'(exp_q.size()), 32'd0);
    check_eq("rand_errs", 32'(err_seen), 32'(exp_err));
    check_eq("rand_ovf", 32'(overflow), 32'(m_ovf));
    check_eq("rand_count", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth in entries; legal values are powers of 2 from 2 to 16.
REQ-002 Parameter TIMEOUT_CYC, default 100000, SHALL set the idle CLOCK_50 cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
REQ-003 CLOCK_50  input  1  system clock; all logic SHALL be on the rising edge.
REQ-004 Resetn  input  1  reset, synchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the pad, asynchronous.
REQ-006 ps2_dat  input  1  raw PS/2 data from the pad, asynchronous.
REQ-007 evt_valid  output  1  high while the FIFO holds at least one event.
REQ-008 evt_ready  input  1  consumer accept; an event SHALL pop on any cycle with evt_valid & evt_ready.
REQ-009 evt_code  output  8  scan code of the head event.
REQ-010 evt_break  output  1  head event is a key release (F0-prefixed).
REQ-011 evt_ext  output  1  head event is extended (E0-prefixed).
REQ-012 evt_shift  output  1  shift state after the head event has been applied.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  number of queued events.
REQ-014 frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-015 overflow  output  1  sticky flag, set when an event is dropped because the FIFO is full.

Function
REQ-016 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized clock (previous 1, current 0).
REQ-017 The receiver FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL sample the synchronized ps2_dat only on a detected falling edge.
REQ-018 In IDLE, a sampled 0 (start bit) SHALL move the FSM to DATA; a sampled 1 SHALL keep it in IDLE with no error.
REQ-019 DATA SHALL shift in 8 bits LSB first, then move to PARITY; PARITY SHALL capture one bit, then move to STOP.
REQ-020 In STOP, the frame SHALL be accepted only if the stop bit is 1 and data plus parity have odd parity; otherwise frame_err SHALL pulse and the byte SHALL be discarded; the FSM SHALL then return to IDLE in either case.
REQ-021 In DATA, PARITY or STOP, if TIMEOUT_CYC cycles pass with no falling edge, frame_err SHALL pulse, the partial frame SHALL be discarded and the FSM SHALL return to IDLE; the timeout counter SHALL reset on every falling edge.
REQ-022 An accepted byte 0xE0 SHALL set the pending-ext flag and SHALL produce no event.
REQ-023 An accepted byte 0xF0 SHALL set the pending-break flag and SHALL produce no event.
REQ-024 Any other accepted byte SHALL produce one event {code, pending-break, pending-ext, shift} and SHALL clear both pending flags.
REQ-025 Rejected frames SHALL leave the pending flags unchanged.
REQ-026 Shift state SHALL be set by a non-extended make of 0x12 or 0x59, and cleared by a non-extended break of either code.
REQ-027 Extended 0x12 and 0x59 SHALL NOT change the shift state; shift events SHALL still be enqueued.
REQ-028 Latency: if the FIFO is empty and not popping, evt_valid SHALL rise exactly 2 cycles after the cycle in which the stop-bit falling edge is detected.
REQ-029 The FIFO SHALL be first-in first-out; evt_code, evt_break, evt_ext and evt_shift SHALL hold stable while evt_valid & !evt_ready.
REQ-030 If a push arrives while the FIFO is full and no pop occurs in the same cycle, the new event SHALL be dropped and overflow SHALL be set; existing entries SHALL be unaffected.
REQ-031 A simultaneous push and pop when the FIFO is full SHALL succeed, with fifo_count unchanged and no overflow.
REQ-032 A simultaneous push and pop when the FIFO is empty SHALL NOT pop the incoming event; it SHALL appear at the head on the next cycle.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-034 While Resetn=0 at a clock edge: the FSM SHALL go to IDLE; the bit counter, timeout counter, pending flags, shift state, FIFO pointers and overflow SHALL be cleared.
REQ-035 While Resetn=0 at a clock edge: evt_valid=0, fifo_count=0, frame_err=0, and evt_code, evt_break, evt_ext and evt_shift SHALL read 0.
REQ-036 The synchronizer flops SHALL reset to 1 (idle bus), so reset itself creates no false falling edge.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after reset release SHALL be decoded normally.

Verification
REQ-038 Frame 0x1C, evt_ready=1 -> one event: code=0x1C, break=0, ext=0, shift=0; evt_valid rises 2 cycles after the stop edge.
REQ-039 Frames 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12 -> four events, in order: (12,b0,s1), (1C,b0,s1), (1C,b1,s1), (12,b1,s0).
REQ-040 Frames 0xE0, 0xF0, 0x75 -> one event: code=0x75, break=1, ext=1; then frames 0xE0, 0x12 -> event ext=1 and shift unchanged.
REQ-041 Frame 0x1C with bad parity, then a good frame 0x1C -> exactly one frame_err pulse, then one event code=0x1C; a bad frame between 0xF0 and 0x1C still yields break=1.
REQ-042 evt_ready=0 with FIFO_DEPTH+1 makes 0x15, 0x1D, 0x24, 0x2D, 0x2C -> fifo_count=4, overflow=1; draining returns 15, 1D, 24, 2D.
REQ-043 Start bit plus 5 data bits, then an idle bus -> frame_err pulses TIMEOUT_CYC cycles after the last edge; a following frame 0x1C decodes correctly; Resetn pulsed mid-frame -> no event and no frame_err.
